// File: rtl/odd_chk_pkg.sv
// Shared types and constants for the odd-sequence checker.
// The observed counter steps by COUNT_STEP and must only ever produce odd values.
package odd_chk_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        RESYNC = 2'd2
    } chk_state_e;

    localparam int COUNT_STEP = 2;

    // Only the LSB decides oddness, so callers pass it directly and stay width-agnostic.
    function automatic logic is_odd(input logic lsb);
        return lsb;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter: adds 1 (inc_i) or 2 (inc2_i) per cycle and sticks at all-ones.
// A synchronous clear wins over any increment requested in the same cycle.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             inc2_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] step;

    always_comb begin
        step = '0;
        if (inc2_i) begin
            step = CNT_W'(2);
        end else if (inc_i) begin
            step = CNT_W'(1);
        end

        // Compare against the headroom instead of adding first, so the sum can never wrap.
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q > (CNT_MAX - step)) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_q + step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/odd_sequence_checker.sv
// Passive monitor that locks onto an odd counter stream (step +2, modulo 2^WIDTH),
// flags mismatches and even values, keeps saturating statistics and re-locks after errors.
module odd_sequence_checker
    import odd_chk_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 16,
    parameter int START_VAL = 1,
    parameter bit LOCK_ANY  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic             count_valid_i,
    input  logic             clr_stats_i,
    output logic             locked_o,
    output logic             mismatch_o,
    output logic             parity_err_o,
    output logic             sticky_err_o,
    output logic [WIDTH-1:0] expected_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic [CNT_W-1:0] error_cnt_o
);

    localparam logic [WIDTH-1:0] START_W = WIDTH'(START_VAL);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(COUNT_STEP);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             locked_q, mismatch_q, parity_q, sticky_q;
    logic             mismatch_d, parity_d, match_d, sticky_d;
    logic             sample_odd;

    assign sample_odd = is_odd(count_i[0]);

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        mismatch_d = 1'b0;
        parity_d   = 1'b0;
        match_d    = 1'b0;

        if (count_valid_i) begin
            parity_d = !sample_odd;
            unique case (state_q)
                SEARCH: begin
                    if ((count_i == START_W) || (LOCK_ANY && sample_odd)) begin
                        state_d    = LOCKED;
                        expected_d = count_i + STEP_W;
                    end
                end
                LOCKED: begin
                    if (count_i == expected_q) begin
                        expected_d = expected_q + STEP_W;
                        match_d    = 1'b1;
                    end else begin
                        // Keep the old expectation visible so the faulty step can be diagnosed.
                        mismatch_d = 1'b1;
                        state_d    = RESYNC;
                    end
                end
                RESYNC: begin
                    if (sample_odd) begin
                        state_d    = LOCKED;
                        expected_d = count_i + STEP_W;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // A same-cycle error must survive a clear request.
        if (mismatch_d || parity_d) begin
            sticky_d = 1'b1;
        end else if (clr_stats_i) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= SEARCH;
            expected_q <= START_W;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            parity_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            locked_q   <= (state_d == LOCKED);
            mismatch_q <= mismatch_d;
            parity_q   <= parity_d;
            sticky_q   <= sticky_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (match_d),
        .inc2_i  (1'b0),
        .clr_i   (clr_stats_i),
        .cnt_o   (match_cnt_o)
    );

    // A wrong sample that is also even counts as two events.
    sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (mismatch_d | parity_d),
        .inc2_i  (mismatch_d & parity_d),
        .clr_i   (clr_stats_i),
        .cnt_o   (error_cnt_o)
    );

    assign locked_o     = locked_q;
    assign mismatch_o   = mismatch_q;
    assign parity_err_o = parity_q;
    assign sticky_err_o = sticky_q;
    assign expected_o   = expected_q;

endmodule

// File: tb/tb_odd_sequence_checker.sv
// Bench for odd_sequence_checker: three instances (default, WIDTH=4 with LOCK_ANY, CNT_W=2)
// share one stimulus stream and are checked against a behavioural model plus a vector table.
module tb_odd_sequence_checker;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] count = '0;

    logic        lk [ND];
    logic        mm [ND];
    logic        pe [ND];
    logic        st [ND];
    logic [31:0] ex [ND];
    logic [15:0] mc [ND];
    logic [15:0] ec [ND];
    logic [3:0]  ex_b;
    logic [1:0]  mc_c, ec_c;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state: mode 0 = hunting for a start, 1 = tracking, 2 = recovering.
    int          m_mode [ND];
    logic [31:0] m_exp  [ND];
    int          m_mc   [ND];
    int          m_ec   [ND];
    bit          m_st   [ND];
    bit          m_mm   [ND];
    bit          m_pe   [ND];
    logic [31:0] m_mask [ND] = '{32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFFF};
    int          m_cmax [ND] = '{65535, 65535, 3};
    bit          m_lany [ND] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    odd_sequence_checker #(.WIDTH(32), .CNT_W(16), .START_VAL(1), .LOCK_ANY(1'b0)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .count_i(count), .count_valid_i(valid),
        .clr_stats_i(clr), .locked_o(lk[0]), .mismatch_o(mm[0]), .parity_err_o(pe[0]),
        .sticky_err_o(st[0]), .expected_o(ex[0]), .match_cnt_o(mc[0]), .error_cnt_o(ec[0])
    );

    odd_sequence_checker #(.WIDTH(4), .CNT_W(16), .START_VAL(1), .LOCK_ANY(1'b1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .count_i(count[3:0]), .count_valid_i(valid),
        .clr_stats_i(clr), .locked_o(lk[1]), .mismatch_o(mm[1]), .parity_err_o(pe[1]),
        .sticky_err_o(st[1]), .expected_o(ex_b), .match_cnt_o(mc[1]), .error_cnt_o(ec[1])
    );

    odd_sequence_checker #(.WIDTH(32), .CNT_W(2), .START_VAL(1), .LOCK_ANY(1'b0)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .count_i(count), .count_valid_i(valid),
        .clr_stats_i(clr), .locked_o(lk[2]), .mismatch_o(mm[2]), .parity_err_o(pe[2]),
        .sticky_err_o(st[2]), .expected_o(ex[2]), .match_cnt_o(mc_c), .error_cnt_o(ec_c)
    );

    assign ex[1] = {28'd0, ex_b};
    assign mc[2] = {14'd0, mc_c};
    assign ec[2] = {14'd0, ec_c};

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_mode[d] = 0; m_exp[d] = 32'd1; m_mc[d] = 0; m_ec[d] = 0;
            m_st[d] = 1'b0; m_mm[d] = 1'b0; m_pe[d] = 1'b0;
        end
    endtask

    // Sequence rules: odd values only, each one 2 above the last, modulo the counter width.
    task automatic model_step(input bit v, input logic [31:0] c_in, input bit cl);
        for (int d = 0; d < ND; d++) begin
            logic [31:0] c;
            bit mis, par, hit;
            int sum;
            c = c_in & m_mask[d];
            mis = 1'b0; par = 1'b0; hit = 1'b0;
            if (v) begin
                par = (c % 2 == 0);
                if (m_mode[d] == 1) begin
                    if (c == m_exp[d]) begin
                        hit = 1'b1;
                        m_exp[d] = (m_exp[d] + 32'd2) & m_mask[d];
                    end else begin
                        mis = 1'b1;
                        m_mode[d] = 2;
                    end
                end else if ((c % 2 == 1) && (m_mode[d] == 2 || c == 1 || m_lany[d])) begin
                    m_mode[d] = 1;
                    m_exp[d] = (c + 32'd2) & m_mask[d];
                end
            end
            sum = m_mc[d] + int'(hit);
            m_mc[d] = cl ? 0 : ((sum > m_cmax[d]) ? m_cmax[d] : sum);
            sum = m_ec[d] + int'(mis) + int'(par);
            m_ec[d] = cl ? 0 : ((sum > m_cmax[d]) ? m_cmax[d] : sum);
            m_st[d] = (mis || par) ? 1'b1 : (cl ? 1'b0 : m_st[d]);
            m_mm[d] = mis;
            m_pe[d] = par;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s d%0d locked", tag, d), lk[d], (m_mode[d] == 1));
            chk($sformatf("%s d%0d mismatch", tag, d), mm[d], m_mm[d]);
            chk($sformatf("%s d%0d parity", tag, d), pe[d], m_pe[d]);
            chk($sformatf("%s d%0d sticky", tag, d), st[d], m_st[d]);
            chk($sformatf("%s d%0d expected", tag, d), ex[d], m_exp[d]);
            chk($sformatf("%s d%0d match_cnt", tag, d), mc[d], m_mc[d]);
            chk($sformatf("%s d%0d error_cnt", tag, d), ec[d], m_ec[d]);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input bit v, input logic [31:0] c, input bit cl, input string tag);
        valid = v; count = c; clr = cl;
        model_step(v, c, cl);
        @(posedge clk);
        #1;
        $display("txn %s: valid=%0d count=%0d clr=%0d -> locked=%0d exp=%0d match=%0d err=%0d",
                 tag, v, c, cl, lk[0], ex[0], mc[0], ec[0]);
        compare_all(tag);
    endtask

    // Pulse reset mid-cycle; outputs must drop while reset is still low.
    task automatic async_reset(input string tag);
        valid = 1'b0; clr = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        $display("txn %s: async reset asserted", tag);
        compare_all(tag);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          v;
        logic [31:0] c;
        bit          cl;
        bit          lk, mm, pe, st;
        logic [31:0] ex;
        int          mc, ec;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b1, 32'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3,  0, 0};
        tbl[1]  = '{1'b1, 32'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5,  1, 0};
        tbl[2]  = '{1'b1, 32'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7,  2, 0};
        tbl[3]  = '{1'b1, 32'd7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd9,  3, 0};
        tbl[4]  = '{1'b1, 32'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd9,  3, 1};
        tbl[5]  = '{1'b1, 32'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd17, 3, 1};
        tbl[6]  = '{1'b0, 32'd99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd17, 3, 1};
        tbl[7]  = '{1'b1, 32'd17, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd19, 4, 1};
        tbl[8]  = '{1'b1, 32'd18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd19, 4, 3};
        tbl[9]  = '{1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd19, 4, 4};
        tbl[10] = '{1'b1, 32'd21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd23, 4, 4};
        tbl[11] = '{1'b1, 32'd23, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd25, 0, 0};
        tbl[12] = '{1'b1, 32'd26, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd25, 0, 0};
        tbl[13] = '{1'b1, 32'd25, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd27, 0, 0};

        // Reset values.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: lock, mismatch, resync, idle cycle, even-while-locked, clear priority.
        for (int i = 0; i < 14; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(tbl[i].v, tbl[i].c, tbl[i].cl, t);
            chk({t, " tbl locked"},   lk[0], tbl[i].lk);
            chk({t, " tbl mismatch"}, mm[0], tbl[i].mm);
            chk({t, " tbl parity"},   pe[0], tbl[i].pe);
            chk({t, " tbl sticky"},   st[0], tbl[i].st);
            chk({t, " tbl expected"}, ex[0], tbl[i].ex);
            chk({t, " tbl match"},    mc[0], tbl[i].mc);
            chk({t, " tbl error"},    ec[0], tbl[i].ec);
        end

        // Wrap across 2^4 on the narrow instance and saturation on the CNT_W=2 instance.
        async_reset("rst1");
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'(2 * k + 1), 1'b0, $sformatf("wrap%0d", k));
        end
        chk("wrap narrow expected", ex[1], 5);
        chk("wrap narrow match", mc[1], 9);
        chk("wrap narrow no mismatch", ec[1], 0);
        chk("wide match", mc[0], 9);
        chk("sat match", mc[2], 3);
        step(1'b1, 32'd21, 1'b1, "clr_with_match");
        chk("clr match", mc[2], 0);
        chk("clr keeps lock", lk[2], 1);

        // Reset while locked, then a non-start odd value must not lock without LOCK_ANY.
        async_reset("rst2");
        step(1'b1, 32'd23, 1'b0, "post_reset");
        chk("post reset search", lk[0], 0);
        chk("post reset expected", ex[0], 1);
        chk("lock_any locks", lk[1], 1);

        // Randomised stream, mostly following the wide instance's expectation.
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [31:0] c;
            if ($urandom_range(0, 299) == 0) begin
                async_reset($sformatf("rnd_rst%0d", i));
            end
            r = int'($urandom_range(0, 9));
            if (r < 6) c = m_exp[0];
            else if (r < 8) c = 32'($urandom_range(0, 40));
            else c = $urandom;
            step($urandom_range(0, 9) != 0, c, $urandom_range(0, 24) == 0,
                 $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/odd_sequence_checker.md
Name: odd_sequence_checker

Overview:
Passive monitor that sits on the output of the odd counter and checks that it produces the sequence START_VAL, +2, +2, … with modulo 2^WIDTH wrap. It locks onto the stream and flags every mismatch and every even value. It keeps saturating statistics and re-synchronises after an error. It is used both as an on-chip health monitor and as the checking end in counter benches.

Parameters:
WIDTH, 32, width of the observed count.
CNT_W, 16, width of each statistics counter.
START_VAL, 1, value the checker must see to lock from SEARCH; must be odd.
LOCK_ANY, 0, 1 = SEARCH locks on any odd value instead of only START_VAL.

Ports:
Clk  input  1  rising-edge clock.
Rst_l  input  1  asynchronous active-low reset.
Count  input  WIDTH  observed counter value.
Count_Valid  input  1  Count is sampled only on cycles where this is 1.
Clr_Stats  input  1  synchronous clear of Match_Cnt, Error_Cnt and Sticky_Err.
Locked  output  1  1 while the state is LOCKED.
Mismatch  output  1  one-cycle pulse: a sampled value differed from Expected while LOCKED.
Parity_Err  output  1  one-cycle pulse: a sampled value was even (any state).
Sticky_Err  output  1  set by Mismatch or Parity_Err; held until Clr_Stats or reset.
Expected  output  WIDTH  next value the checker expects.
Match_Cnt  output  CNT_W  saturating count of correct samples while LOCKED.
Error_Cnt  output  CNT_W  saturating count of Mismatch and Parity_Err events.

Behaviour:
- Reset (async, Rst_l=0):
  - state SEARCH.
  - Expected = START_VAL.
  - Locked, Mismatch, Parity_Err, Sticky_Err = 0.
  - Match_Cnt, Error_Cnt = 0.
- Reset mid-operation aborts any lock immediately. After release, the first valid sample is judged from SEARCH.
- All outputs are registered. An event caused by the sample at edge N is visible after edge N.
- Cycles with Count_Valid=0 change nothing: state, Expected and counters hold, pulses are 0.
- Arithmetic: next expected value = Count + 2, truncated to WIDTH bits. So 2^WIDTH-1 wraps to 1. This wrap is legal and is not an error.
- Parity_Err fires whenever a valid sample has Count[0]=0, in any state.
- State SEARCH, on a valid sample:
  - Count==START_VAL, or (LOCK_ANY=1 and Count odd): go to LOCKED, Expected <= Count+2. Match_Cnt is not incremented.
  - Otherwise: stay in SEARCH.
- State LOCKED, on a valid sample:
  - Count==Expected: stay, Expected <= Expected+2, Match_Cnt++.
  - Count!=Expected: pulse Mismatch, Error_Cnt++, go to RESYNC, Expected unchanged.
  - If the wrong sample is also even, Mismatch and Parity_Err both pulse and Error_Cnt increments by 2 (saturating).
- State RESYNC, on a valid sample:
  - Count odd: go to LOCKED, Expected <= Count+2. Always locks on any odd value, regardless of LOCK_ANY.
  - Count even: stay in RESYNC, Parity_Err pulses.
- Locked = (state==LOCKED), registered with the state.
- Statistics counters saturate at all-ones and never wrap.
- Clr_Stats:
  - Takes priority over a same-cycle increment: result is 0 and that increment is lost.
  - Clears Sticky_Err, but a same-cycle error leaves Sticky_Err=1.
  - Does not affect state, Expected or Locked.
- Count is treated as synchronous to Clk; the checker adds no CDC logic.

Decomposition:
- Package odd_chk_pkg:
  - state typedef enum logic [1:0] {SEARCH, LOCKED, RESYNC}.
  - localparam COUNT_STEP = 2.
  - helper function is_odd().
- Sub-module sat_counter (CNT_W parameter; inputs inc, inc2, clr), instantiated twice for Match_Cnt and Error_Cnt.
- The FSM and the Expected register live in the top module.

Test Plan:
1. Reset, then feed valid 1,3,5,7,9 -> Locked=1 after the first edge; Match_Cnt=4; Error_Cnt=0; Expected=11; no pulses.
2. Locked at Expected=9, feed 13 -> Mismatch for 1 cycle, Error_Cnt=1, Sticky_Err=1, state RESYNC. Then feed 15 -> Locked=1, Expected=17.
3. WIDTH=4, feed 1,3,…,13,15,1,3 -> no Mismatch across the 15->1 wrap; Match_Cnt=9; Expected=5.
4. Feed even 6 while LOCKED with Expected=7 -> Mismatch and Parity_Err pulse together, Error_Cnt=2. Then feed 8 -> Parity_Err only, still RESYNC.
5. CNT_W=2, feed 5 correct samples -> Match_Cnt saturates at 3. Then Clr_Stats=1 in the same cycle as a correct sample -> Match_Cnt=0, Locked stays 1.
6. Locked at Expected=21, drop Rst_l for 3 ns mid-cycle -> outputs go to reset values immediately. Then feed 21 with LOCK_ANY=0 -> stays in SEARCH, Locked=0.
